// File: rtl/alu_ops_pkg.sv
// ----------------------------------------------------------------------------
// alu_ops_pkg : shared ALU op codes and sequencer state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_ops_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_ADD = 3'b000;
  localparam alu_op_t OP_SUB = 3'b001;
  localparam alu_op_t OP_AND = 3'b010;
  localparam alu_op_t OP_OR  = 3'b011;
  localparam alu_op_t OP_SLT = 3'b100;
  localparam alu_op_t OP_SLL = 3'b101;
  localparam alu_op_t OP_SRL = 3'b110;
  localparam alu_op_t OP_SRA = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_unit_if.sv
// ----------------------------------------------------------------------------
// alu_seq_unit_if : request/result bundle between operand muxes and the ALU
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_seq_unit_if #(
  parameter int DATA_WIDTH = 32
);
  import alu_ops_pkg::*;

  logic                  en;
  logic                  start;
  alu_op_t               ALUControl;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;
  logic                  busy;
  logic                  done;

  modport master (
    output en, start, ALUControl, SrcA, SrcB,
    input  ALUResult, Zero, busy, done
  );

  modport slave (
    input  en, start, ALUControl, SrcA, SrcB,
    output ALUResult, Zero, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/alu_shift_step.sv
// ----------------------------------------------------------------------------
// alu_shift_step : combinational one-position shift (left, logical or arith right)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_shift_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  right_i,
  input  logic                  arith_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    if (right_i) begin
      data_o = {arith_i & data_i[DATA_WIDTH-1], data_i[DATA_WIDTH-1:1]};
    end else begin
      data_o = {data_i[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_unit.sv
// ----------------------------------------------------------------------------
// alu_seq_unit : registered ALU, single-cycle logic/arith, bit-serial shifts
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_seq_unit
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_unit_if.slave  bus
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [1:0]            state_q, state_d;
  logic [SHW-1:0]        cnt_q, cnt_d;
  alu_op_t               op_q, op_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;

  logic [DATA_WIDTH-1:0] w_alu_res;
  logic [DATA_WIDTH-1:0] w_shift_res;
  logic [SHW-1:0]        w_shamt;
  logic                  w_lt;

  assign w_shamt = bus.SrcB[SHW-1:0];
  assign w_lt    = $signed(bus.SrcA) < $signed(bus.SrcB);

  always_comb begin
    w_alu_res = '0;
    case (bus.ALUControl)
      OP_ADD:  w_alu_res = bus.SrcA + bus.SrcB;
      OP_SUB:  w_alu_res = bus.SrcA - bus.SrcB;
      OP_AND:  w_alu_res = bus.SrcA & bus.SrcB;
      OP_OR:   w_alu_res = bus.SrcA | bus.SrcB;
      OP_SLT:  w_alu_res = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      default: w_alu_res = '0;
    endcase
  end

  // The result register doubles as the shift register while in SHIFT.
  alu_shift_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_step (
    .data_i  (res_q),
    .right_i (op_q != OP_SLL),
    .arith_i (op_q == OP_SRA),
    .data_o  (w_shift_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    if (bus.en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (!is_shift(bus.ALUControl)) begin
              res_d   = w_alu_res;
              state_d = ST_DONE;
            end else if (w_shamt == '0) begin
              res_d   = bus.SrcA;
              state_d = ST_DONE;
            end else begin
              res_d   = bus.SrcA;
              cnt_d   = w_shamt;
              op_d    = bus.ALUControl;
              state_d = ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          res_d = w_shift_res;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign bus.ALUResult = res_q;
  assign bus.Zero      = (res_q == '0);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_unit : directed and randomized checks of alu_seq_unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq_unit;
  import alu_ops_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_unit_if #(.DATA_WIDTH(32)) bus ();

  alu_seq_unit #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an op is "in flight" for left cycles; done on the last one.
  function automatic logic [31:0] ref_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_shift(input alu_op_t op, input logic [31:0] a, input int n);
    logic signed [31:0] s;
    s = a;
    case (op)
      3'b101:  return a << n;
      3'b110:  return a >> n;
      default: return s >>> n;
    endcase
  endfunction

  int          m_left  = 0;
  int          m_k     = 0;
  int          m_steps = 0;
  logic [31:0] m_a     = '0;
  logic [31:0] m_res   = '0;
  alu_op_t     m_op    = 3'b000;

  always @(posedge clk) begin
    if (rst) begin
      m_left  <= 0;
      m_k     <= 0;
      m_steps <= 0;
      m_res   <= '0;
    end else if (bus.en) begin
      if (m_left == 0) begin
        if (bus.start) begin
          m_a     <= bus.SrcA;
          m_op    <= bus.ALUControl;
          m_steps <= 0;
          if (bus.ALUControl >= 3'b101) begin
            m_k    <= int'(bus.SrcB[4:0]);
            m_left <= int'(bus.SrcB[4:0]) + 1;
            m_res  <= bus.SrcA;
          end else begin
            m_k    <= 0;
            m_left <= 1;
            m_res  <= ref_op(bus.ALUControl, bus.SrcA, bus.SrcB);
          end
        end
      end else begin
        if (m_steps < m_k) begin
          m_steps <= m_steps + 1;
          m_res   <= ref_shift(m_op, m_a, m_steps + 1);
        end
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy",   32'(bus.busy), 32'(m_left > 0));
      check("done",   32'(bus.done), 32'(m_left == 1));
      check("result", bus.ALUResult, m_res);
      check("zero",   32'(bus.Zero), 32'(m_res == 32'd0));
    end
  end

  task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.en         = 1'b1;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL timeout: done not seen, got %b want 1", bus.done);
    end
  endtask

  task automatic run_op(input string name, input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    issue(op, a, b);
    wait_done(lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, bus.ALUResult, exp_res);
    check({name, " zero"}, 32'(bus.Zero), 32'(exp_res == 32'd0));
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.start      = 1'b0;
    bus.ALUControl = OP_ADD;
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.ALUResult, 32'd0);
    check("reset zero", 32'(bus.Zero), 32'd1);
    bus.en = 1'b1;
    @(negedge clk);

    run_op("add",      OP_ADD, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1);
    run_op("sub",      OP_SUB, 32'd5,         32'd5,         32'd0,         1);
    run_op("slt neg",  OP_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1,         1);
    run_op("slt swap", OP_SLT, 32'd1,         32'hFFFF_FFFF, 32'd0,         1);
    run_op("and",      OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    run_op("or",       OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1);
    run_op("sra4",     OP_SRA, 32'h8000_0000, 32'd4,         32'hF800_0000, 5);
    run_op("srl4",     OP_SRL, 32'h8000_0000, 32'd4,         32'h0800_0000, 5);
    run_op("sll31",    OP_SLL, 32'd1,         32'd31,        32'h8000_0000, 32);
    run_op("shamt0",   OP_SLL, 32'h1234,      32'h20,        32'h1234,      1);

    // SRL by 3 with two stalled edges and a start held across a busy edge.
    issue(OP_SRL, 32'h8000_0000, 32'd3);
    lat            = 1;
    bus.en         = 1'b0;
    bus.start      = 1'b1;
    bus.ALUControl = OP_ADD;
    bus.SrcA       = 32'd1;
    bus.SrcB       = 32'd1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 3) bus.en = 1'b1;
      if (lat == 4) bus.start = 1'b0;
    end
    bus.en    = 1'b1;
    bus.start = 1'b0;
    check("stall latency", 32'(lat), 32'd6);
    check("stall result", bus.ALUResult, 32'h1000_0000);
    @(negedge clk);
    check("no second op", 32'(bus.busy), 32'd0);
    check("stall result held", bus.ALUResult, 32'h1000_0000);

    // Reset during the second cycle of a long shift.
    issue(OP_SLL, 32'd1, 32'd10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset busy", 32'(bus.busy), 32'd0);
    check("mid reset done", 32'(bus.done), 32'd0);
    check("mid reset result", bus.ALUResult, 32'd0);
    check("mid reset zero", 32'(bus.Zero), 32'd1);
    run_op("add after reset", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

    for (int i = 0; i < 3000; i++) begin
      bus.en         = ($urandom_range(0, 7) != 0);
      bus.start      = ($urandom_range(0, 2) != 0);
      bus.ALUControl = alu_op_t'($urandom_range(0, 7));
      bus.SrcA       = pick();
      bus.SrcB       = ($urandom_range(0, 1) != 0) ? pick() : 32'($urandom_range(0, 63));
      rst            = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst       = 1'b0;
    bus.en    = 1'b1;
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
